// File: rtl/therm_pkg.sv
// Shared types and helpers for the flash-ADC thermometer path.
package therm_pkg;

  localparam int N_COMP_DEF = 15;
  localparam int BCNT_W     = 8;

  typedef logic [N_COMP_DEF-1:0] therm_t;

  // Legal thermometer word with the lowest 'count' bits set.
  function automatic therm_t therm_from_count(input int unsigned count);
    therm_t t;
    for (int i = 0; i < N_COMP_DEF; i++) begin
      t[i] = (i < count);
    end
    return t;
  endfunction

endpackage

// File: rtl/therm_sync.sv
// Multi-bit, STAGES-deep flop synchronizer for the asynchronous comparator outputs.
module therm_sync #(
  parameter int W      = 15,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/therm_capture.sv
// Comparator capture, 3-tap majority bubble correction and output handshake register.
// Optional saturating bubble counter enabled by defining THERM_BUBBLE_CNT_EN.
module therm_capture
  import therm_pkg::*;
#(
  parameter int N_COMP      = N_COMP_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_COMP-1:0] comp_in,
  input  logic              sample_en,
  output logic [N_COMP-1:0] therm_out,
  output logic              therm_valid,
  input  logic              therm_ready,
  output logic              bubble_err,
  output logic              overrun,
  output logic [BCNT_W-1:0] bubble_cnt,
  input  logic              cnt_clr
);

  localparam int POP_W = $clog2(N_COMP + 1);

  logic [N_COMP-1:0] w_sync_q;
  logic [N_COMP-1:0] r_cap;
  logic              r_cap_vld;
  logic [N_COMP+1:0] w_ext;
  logic [N_COMP-1:0] w_maj;
  logic [POP_W-1:0]  w_pop;
  logic [N_COMP-1:0] w_corr;
  logic              w_accept;

  therm_sync #(.W(N_COMP), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (comp_in),
    .o_q   (w_sync_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= sample_en;
      if (sample_en) begin
        r_cap <= w_sync_q;
      end
    end
  end

  // Pad with a 1 below the lowest threshold and a 0 above the highest.
  assign w_ext = {1'b0, r_cap, 1'b1};

  always_comb begin
    w_maj  = '0;
    w_pop  = '0;
    w_corr = '0;
    for (int i = 0; i < N_COMP; i++) begin
      w_maj[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) |
                 (w_ext[i+1] & w_ext[i+2]);
    end
    for (int i = 0; i < N_COMP; i++) begin
      w_pop = w_pop + POP_W'(w_maj[i]);
    end
    for (int i = 0; i < N_COMP; i++) begin
      w_corr[i] = (i < int'(w_pop));
    end
  end

  // Handshake: a word transfers in any cycle where therm_valid && therm_ready.
  // While valid && !ready the word is held, unless a newer sample overwrites
  // it (overrun). A load in the acceptance cycle replaces it cleanly.
  assign w_accept = therm_valid & therm_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      therm_out   <= '0;
      therm_valid <= 1'b0;
      bubble_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      bubble_err <= r_cap_vld && (r_cap != w_corr);
      if (r_cap_vld) begin
        therm_out   <= w_corr;
        therm_valid <= 1'b1;
      end else if (w_accept) begin
        therm_valid <= 1'b0;
      end
      if (r_cap_vld && therm_valid && !therm_ready) begin
        overrun <= 1'b1;
      end else if (cnt_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef THERM_BUBBLE_CNT_EN
  logic [BCNT_W-1:0] r_bcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt <= '0;
    end else if (cnt_clr) begin
      r_bcnt <= bubble_err ? BCNT_W'(1) : '0;
    end else if (bubble_err && (r_bcnt != '1)) begin
      r_bcnt <= r_bcnt + BCNT_W'(1);
    end
  end

  assign bubble_cnt = r_bcnt;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_therm_capture.sv
// Directed self-checking bench for therm_capture (default parameters).
module tb_therm_capture;

  logic        clk;
  logic        rst_n;
  logic [14:0] comp_in;
  logic        sample_en;
  logic [14:0] therm_out;
  logic        therm_valid;
  logic        therm_ready;
  logic        bubble_err;
  logic        overrun;
  logic [7:0]  bubble_cnt;
  logic        cnt_clr;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

`ifdef THERM_BUBBLE_CNT_EN
  localparam logic [7:0] EXP_CNT1 = 8'd1;
  localparam logic [7:0] EXP_SAT  = 8'hFF;
`else
  localparam logic [7:0] EXP_CNT1 = 8'd0;
  localparam logic [7:0] EXP_SAT  = 8'd0;
`endif

  therm_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .comp_in     (comp_in),
    .sample_en   (sample_en),
    .therm_out   (therm_out),
    .therm_valid (therm_valid),
    .therm_ready (therm_ready),
    .bubble_err  (bubble_err),
    .overrun     (overrun),
    .bubble_cnt  (bubble_cnt),
    .cnt_clr     (cnt_clr)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold v until it is through the synchronizer, strobe once, return in cycle T+2.
  task automatic strobe_one(input logic [14:0] v);
    comp_in = v;
    repeat (3) tick();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; comp_in = '0; sample_en = 1'b0; therm_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) tick();
    checks++; if (therm_out !== 15'h0) begin errors++; $display("FAIL reset_out got=%h exp=%h", therm_out, 15'h0); end
    checks++; if (therm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", therm_valid); end
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL reset_berr got=%b exp=0", bubble_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (bubble_cnt !== 8'h0) begin errors++; $display("FAIL reset_bcnt got=%h exp=00", bubble_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    strobe_one(15'h007F);
    checks++; if (therm_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", therm_valid); end
    checks++; if (therm_out !== 15'h007F) begin errors++; $display("FAIL basic_out got=%h exp=%h", therm_out, 15'h007F); end
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL basic_berr got=%b exp=0", bubble_err); end
    tick();
    checks++; if (therm_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b exp=0", therm_valid); end
  endtask

  task automatic test_bubble();
    strobe_one(15'h00DF);
    checks++; if (therm_out !== 15'h00FF) begin errors++; $display("FAIL bubble_out got=%h exp=%h", therm_out, 15'h00FF); end
    checks++; if (bubble_err !== 1'b1) begin errors++; $display("FAIL bubble_berr got=%b exp=1", bubble_err); end
    tick();
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL bubble_pulse got=%b exp=0", bubble_err); end
    checks++; if (bubble_cnt !== EXP_CNT1) begin errors++; $display("FAIL bubble_cnt got=%h exp=%h", bubble_cnt, EXP_CNT1); end
  endtask

  task automatic test_boundary();
    strobe_one(15'h4000);
    checks++; if (therm_out !== 15'h0000) begin errors++; $display("FAIL stray_out got=%h exp=%h", therm_out, 15'h0); end
    checks++; if (bubble_err !== 1'b1) begin errors++; $display("FAIL stray_berr got=%b exp=1", bubble_err); end
    checks++; if (therm_valid !== 1'b1) begin errors++; $display("FAIL stray_valid got=%b exp=1", therm_valid); end
    strobe_one(15'h7FFF);
    checks++; if (therm_out !== 15'h7FFF) begin errors++; $display("FAIL ones_out got=%h exp=%h", therm_out, 15'h7FFF); end
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL ones_berr got=%b exp=0", bubble_err); end
    strobe_one(15'h0000);
    checks++; if (therm_out !== 15'h0000) begin errors++; $display("FAIL zero_out got=%h exp=%h", therm_out, 15'h0); end
    checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL zero_berr got=%b exp=0", bubble_err); end
    checks++; if (therm_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", therm_valid); end
  endtask

  task automatic test_overrun();
    logic [14:0] vals [3];
    vals[0] = 15'h0001; vals[1] = 15'h0003; vals[2] = 15'h0007;
    therm_ready = 1'b0;
    // comp_in in cycle k reaches sync_q in cycle k+2, so strobes lag by two.
    for (int k = 0; k <= 6; k++) begin
      tick();
      comp_in   = (k < 3) ? vals[k] : 15'h0007;
      sample_en = (k >= 2 && k <= 4);
    end
    checks++; if (therm_out !== 15'h0007) begin errors++; $display("FAIL ovr_out got=%h exp=%h", therm_out, 15'h0007); end
    checks++; if (therm_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", therm_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    repeat (3) tick();
    checks++; if (therm_out !== 15'h0007) begin errors++; $display("FAIL ovr_hold_out got=%h exp=%h", therm_out, 15'h0007); end
    checks++; if (therm_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid got=%b exp=1", therm_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
    checks++; if (therm_valid !== 1'b1) begin errors++; $display("FAIL ovr_clr_valid got=%b exp=1", therm_valid); end
    therm_ready = 1'b1;
    tick();
    checks++; if (therm_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%b exp=0", therm_valid); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] vals [6];
    logic [14:0] exp_v;
    vals[0] = 15'h0001; vals[1] = 15'h0003; vals[2] = 15'h0007;
    vals[3] = 15'h000F; vals[4] = 15'h001F; vals[5] = 15'h003F;
    therm_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      comp_in   = (k < 6) ? vals[k] : 15'h0;
      sample_en = (k >= 2 && k < 8);
      if (k >= 2 && k < 8) exp_q.push_back(vals[k-2]);
      if (k >= 4 && k < 10) begin
        exp_v = exp_q.pop_front();
        checks++; if (therm_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, therm_valid); end
        checks++; if (therm_out !== exp_v) begin errors++; $display("FAIL b2b_out k=%0d got=%h exp=%h", k, therm_out, exp_v); end
      end else begin
        checks++; if (therm_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle k=%0d got=%b exp=0", k, therm_valid); end
      end
      checks++; if (bubble_err !== 1'b0) begin errors++; $display("FAIL b2b_berr k=%0d got=%b exp=0", k, bubble_err); end
    end
    sample_en = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    comp_in = 15'h003F;
    repeat (3) tick();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (therm_valid !== 1'b0) begin errors++; $display("FAIL rst_flight k=%0d got=%b exp=0", k, therm_valid); end
    end
  endtask

  task automatic test_saturation();
    comp_in = 15'h4000;
    therm_ready = 1'b1;
    repeat (3) tick();
    sample_en = 1'b1;
    repeat (300) tick();
    sample_en = 1'b0;
    repeat (4) tick();
    checks++; if (bubble_cnt !== EXP_SAT) begin errors++; $display("FAIL sat_cnt got=%h exp=%h", bubble_cnt, EXP_SAT); end
    strobe_one(15'h4000);
    checks++; if (bubble_err !== 1'b1) begin errors++; $display("FAIL clr_inc_berr got=%b exp=1", bubble_err); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (bubble_cnt !== EXP_CNT1) begin errors++; $display("FAIL clr_inc_cnt got=%h exp=%h", bubble_cnt, EXP_CNT1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_boundary();
    test_overrun();
    test_back_to_back();
    test_reset_midflight();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
